// File: rtl/apb_ram_ws_if.sv
// APB4 bus bundle shared by the wait-state RAM slave and whatever masters it.
// Signal names follow the APB4 protocol names.
interface apb_ram_ws_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_ws.sv
// Parametrised APB4 slave RAM with configurable wait states, byte strobes,
// address-error response and registered read data / ready / error.
module apb_ram_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        pclk,
  input  logic        preset,
  apb_ram_ws_if.slave apb
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX   = $clog2(DEPTH);
  localparam int OFF   = $clog2(BYTES);
  localparam logic [64:0]           SPAN       = 65'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic [IDX-1:0]          idx_r, idx_s;
  logic                    wr_r, wr_s;
  logic                    err_r, err_s;
  logic                    pready_r, pready_s;
  logic                    pslverr_r, pslverr_s;
  logic [DATA_WIDTH-1:0]   prdata_r, prdata_s;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

  logic [IDX-1:0]          bus_idx_s;
  logic                    bus_err_s;
  logic                    commit_s;

  // Misalignment uses a mask so the single-byte-lane build needs no special case.
  assign bus_idx_s = apb.paddr[OFF +: IDX];
  assign bus_err_s = (65'(apb.paddr) >= SPAN) || ((apb.paddr & ALIGN_MASK) != '0);
  assign commit_s  = pready_r && apb.psel && apb.penable && apb.pwrite && wr_r && !err_r;

  assign apb.pready  = pready_r;
  assign apb.pslverr = pslverr_r;
  assign apb.prdata  = prdata_r;

  // Next-state and next-output logic; response registers load on entry to RESP.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    wr_s      = wr_r;
    err_s     = err_r;
    pready_s  = 1'b0;
    pslverr_s = 1'b0;
    prdata_s  = '0;
    case (state_r)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          idx_s = bus_idx_s;
          wr_s  = apb.pwrite;
          err_s = bus_err_s;
          if (WAIT_STATES == 0) begin
            state_s   = RESP;
            pready_s  = 1'b1;
            pslverr_s = bus_err_s;
            prdata_s  = bus_err_s ? '0 : mem_r[bus_idx_s];
          end else begin
            state_s = WAIT;
            cnt_s   = 4'(WAIT_STATES - 1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!apb.psel) begin
          state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          state_s   = RESP;
          pready_s  = 1'b1;
          pslverr_s = err_r;
          prdata_s  = err_r ? '0 : mem_r[idx_r];
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, latched transfer attributes and registered response outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= '0;
      wr_r      <= 1'b0;
      err_r     <= 1'b0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      wr_r      <= wr_s;
      err_r     <= err_s;
      pready_r  <= pready_s;
      pslverr_r <= pslverr_s;
      prdata_r  <= prdata_s;
    end
  end

  // Storage: cleared by reset, byte-lane writes committed on the RESP edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (commit_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (apb.pstrb[b]) begin
          mem_r[idx_r][8*b +: 8] <= apb.pwdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_ram_ws.sv
// Scoreboard bench for apb_ram_ws: a 2-wait-state and a zero-wait instance,
// driven with directed APB transfers whose responses are checked by monitors.
module tb_apb_ram_ws;
  logic pclk = 1'b0;
  logic preset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rdy2 = 0;
  int   rdy0 = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          err;
    int          setup_cyc;
    int          lat;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_ram_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2();
  apb_ram_ws_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0();

  apb_ram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) dut2 (
    .pclk(pclk), .preset(preset), .apb(bus2)
  );
  apb_ram_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .apb(bus0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the 2-wait-state instance.
  always @(negedge pclk) begin
    if (bus2.pready === 1'b1) begin
      rdy2++;
      if (q2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ws2_unexpected_pready: got pready=1 expected no response at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("ws2_latency", 32'(cyc - e.setup_cyc), 32'(e.lat));
        check("ws2_pslverr", 32'(bus2.pslverr), 32'(e.err));
        if (e.is_read) check("ws2_prdata", bus2.prdata, e.data);
      end
    end
  end

  // Monitor for the zero-wait instance.
  always @(negedge pclk) begin
    if (bus0.pready === 1'b1) begin
      rdy0++;
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ws0_unexpected_pready: got pready=1 expected no response at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("ws0_latency", 32'(cyc - e.setup_cyc), 32'(e.lat));
        check("ws0_pslverr", 32'(bus0.pslverr), 32'(e.err));
        if (e.is_read) check("ws0_prdata", bus0.prdata, e.data);
      end
    end
  end

  task automatic drive(input int ws, input bit sel, input bit en, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (ws == 0) begin
      bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr;
      bus0.paddr = addr; bus0.pwdata = data; bus0.pstrb = strb;
    end else begin
      bus2.psel = sel; bus2.penable = en; bus2.pwrite = wr;
      bus2.paddr = addr; bus2.pwdata = data; bus2.pstrb = strb;
    end
  endtask

  task automatic set_en(input int ws);
    if (ws == 0) bus0.penable = 1'b1;
    else         bus2.penable = 1'b1;
  endtask

  task automatic idle(input int n);
    @(posedge pclk); #1;
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (n) @(posedge pclk);
  endtask

  // One full APB transfer; the next call starts its setup in the cycle after RESP.
  task automatic xfer(input int ws, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [31:0] exp_data, input bit exp_err);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge pclk); #1;
    e.is_read   = !wr;
    e.data      = exp_data;
    e.err       = exp_err;
    e.setup_cyc = cyc;
    e.lat       = (ws == 0) ? 1 : 3;
    drive(ws, 1'b1, 1'b0, wr, addr, data, strb);
    if (ws == 0) q0.push_back(e);
    else         q2.push_back(e);
    @(posedge pclk); #1;
    set_en(ws);
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge pclk);
      seen = (ws == 0) ? (bus0.pready === 1'b1) : (bus2.pready === 1'b1);
      n++;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL xfer_timeout: got no pready within 20 cycles expected pready for addr 0x%08h", addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    preset = 1'b1;
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_pready", 32'(bus2.pready), 32'h0);
    check("rst_pslverr", 32'(bus2.pslverr), 32'h0);
    check("rst_prdata", bus2.prdata, 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0;
    idle(1);

    xfer(2, 1'b0, 32'h00, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    idle(1);
    xfer(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(2, 1'b1, 32'h10, 32'h1122_3344, 4'h5, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
    xfer(2, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Range errors: 0x100 aliases word 0 if the error were ignored.
    xfer(2, 1'b1, 32'hFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    xfer(2, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    xfer(2, 1'b0, 32'hFC, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
    xfer(2, 1'b0, 32'h00, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    xfer(2, 1'b1, 32'h08, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h0A, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0);
    idle(1);

    base = rdy2;
    @(posedge pclk); #1;
    drive(2, 1'b1, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    @(posedge pclk); #1;
    set_en(2);
    @(posedge pclk); #1;
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(4);
    check("abort_no_pready", 32'(rdy2), 32'(base));
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    idle(1);

    base = rdy2;
    @(posedge pclk); #1;
    drive(2, 1'b1, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    repeat (4) @(posedge pclk);
    idle(3);
    check("no_setup_ignored", 32'(rdy2), 32'(base));
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
    idle(1);

    base = rdy2;
    @(posedge pclk); #1;
    drive(2, 1'b1, 1'b0, 1'b1, 32'h08, 32'hCAFE_F00D, 4'hF);
    @(posedge pclk); #1;
    set_en(2);
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(3);
    check("rst_mid_no_pready", 32'(rdy2), 32'(base));
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
    idle(1);

    xfer(0, 1'b1, 32'h04, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0);
    xfer(0, 1'b0, 32'h0A, 32'h0, 4'h0, 32'h0000_0000, 1'b1);
    idle(3);

    check("queue_drained", 32'(q2.size() + q0.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
